// File: rtl/gol_if.sv
// Control and row-write bus between the switch/button front end and the Game of Life engine.
interface gol_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
);
  logic                    tick_en;
  logic                    btn_run;
  logic                    btn_step;
  logic                    btn_clear;
  logic                    wr_en;
  logic [$clog2(ROWS)-1:0] wr_row;
  logic [COLS-1:0]         wr_data;

  modport master (
    output tick_en, btn_run, btn_step, btn_clear, wr_en, wr_row, wr_data
  );

  modport slave (
    input tick_en, btn_run, btn_step, btn_clear, wr_en, wr_row, wr_data
  );
endinterface

// File: rtl/gol_engine.sv
// Parametrised ROWS x COLS Game of Life engine with row-serial generation compute.
// Define GOL_TORUS_EN to wrap board edges; otherwise cells outside the board are dead.
module gol_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int CNT_W = 16
) (
  input  logic                 ClkPort,
  input  logic                 reset_n,
  gol_if.slave                 bus,
  output logic [ROWS*COLS-1:0] board_o,
  output logic [CNT_W-1:0]     generation_cnt_o,
  output logic [1:0]           state_o,
  output logic                 busy_o,
  output logic                 stable_o
);

  localparam int IDX_W = $clog2(ROWS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS);

  typedef enum logic [1:0] {
    SET  = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    CALC = 2'b11
  } state_t;

  state_t               state, state_nxt;
  logic [ROWS*COLS-1:0] board, shadow;
  logic [IDX_W-1:0]     row_idx;
  logic                 ret_stop;
  logic [CNT_W-1:0]     cnt;
  logic                 stable;
  logic [COLS-1:0]      next_row;
  logic                 commit, start_calc, wr_ok;

  function automatic logic cell_at(input logic [ROWS*COLS-1:0] b, input int r, input int c);
`ifdef GOL_TORUS_EN
    int rr;
    int cc;
    rr = (r + ROWS) % ROWS;
    cc = (c + COLS) % COLS;
    return b[rr*COLS+cc];
`else
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    return b[r*COLS+c];
`endif
  endfunction

  // Next-generation value of every cell in the row currently being computed.
  always_comb begin
    logic [3:0] n;
    next_row = '0;
    n        = '0;
    for (int c = 0; c < COLS; c++) begin
      n = '0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (dr != 0 || dc != 0) n = n + 4'(cell_at(board, int'(row_idx) + dr, c + dc));
        end
      end
      next_row[c] = (n == 4'd3) | (cell_at(board, int'(row_idx), c) & (n == 4'd2));
    end
  end

  assign commit = (state == CALC) && (row_idx == LAST_IDX);
  assign wr_ok  = bus.wr_en && (int'(bus.wr_row) < ROWS) && (state == SET || state == STOP);

  // Control FSM: clear beats everything, run beats step/tick, busy generations ignore new starts.
  always_comb begin
    state_nxt  = state;
    start_calc = 1'b0;
    unique case (state)
      SET:  if (bus.btn_run) state_nxt = RUN;
      RUN:  begin
        if (bus.btn_run) state_nxt = STOP;
        else if (bus.tick_en) begin
          state_nxt  = CALC;
          start_calc = 1'b1;
        end
      end
      STOP: begin
        if (bus.btn_run) state_nxt = RUN;
        else if (bus.btn_step) begin
          state_nxt  = CALC;
          start_calc = 1'b1;
        end
      end
      CALC: if (commit) state_nxt = (ret_stop || bus.btn_run) ? STOP : RUN;
    endcase
    if (bus.btn_clear) begin
      state_nxt  = SET;
      start_calc = 1'b0;
    end
  end

  always_ff @(posedge ClkPort or negedge reset_n) begin
    if (!reset_n) state <= SET;
    else          state <= state_nxt;
  end

  // Board, shadow buffer, counter and flags; the board only changes on writes, commit or clear.
  always_ff @(posedge ClkPort or negedge reset_n) begin
    if (!reset_n) begin
      board    <= '0;
      shadow   <= '0;
      row_idx  <= '0;
      ret_stop <= 1'b0;
      cnt      <= '0;
      stable   <= 1'b0;
    end else if (bus.btn_clear) begin
      board    <= '0;
      row_idx  <= '0;
      ret_stop <= 1'b0;
      cnt      <= '0;
      stable   <= 1'b0;
    end else begin
      if (wr_ok) begin
        board[int'(bus.wr_row)*COLS +: COLS] <= bus.wr_data;
        stable                               <= 1'b0;
      end
      if (start_calc) begin
        row_idx  <= '0;
        ret_stop <= (state == STOP);
      end else if (state == CALC) begin
        if (bus.btn_run) ret_stop <= 1'b1;
        if (commit) begin
          board   <= shadow;
          cnt     <= cnt + 1'b1;
          stable  <= (shadow == board);
          row_idx <= '0;
        end else begin
          shadow[int'(row_idx)*COLS +: COLS] <= next_row;
          row_idx                            <= row_idx + 1'b1;
        end
      end
    end
  end

  assign board_o          = board;
  assign generation_cnt_o = cnt;
  assign state_o          = state;
  assign busy_o           = (state == CALC);
  assign stable_o         = stable;

endmodule
